// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   One pipeline stage with a main register plus a single skid register, so
//   that in_ready is a registered signal with no combinational path from
//   out_ready. Carries an instruction, its incremented PC and an error flag.
//   While the stage holds no valid entry the outputs show NOP_VAL / 0 / 0.
//
// Parameters
//   DATA_W   width of instruction/payload field
//   PC_W     width of incremented-PC field
//   NOP_VAL  payload shown when empty (resized to DATA_W)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_data/in_pc/in_err      upstream entry
//   out_valid/out_ready       downstream handshake
//   out_data/out_pc/out_err   held entry (NOP_VAL/0/0 when out_valid=0)
//   flush, flush_exempt       discard everything unless exempt this cycle
//   stall_cnt, flush_cnt      saturating performance counters
//                             (present only with PIPE_STAGE_PERF_EN defined)
//
// Optional macro: PIPE_STAGE_PERF_EN
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int          DATA_W  = 16,
  parameter int          PC_W    = 16,
  parameter logic [15:0] NOP_VAL = 16'b0000_1000_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_err,
  input  logic              flush,
  input  logic              flush_exempt
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VAL);

  logic              r_main_vld;
  logic [DATA_W-1:0] r_main_data;
  logic [PC_W-1:0]   r_main_pc;
  logic              r_main_err;

  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_skid_pc;
  logic              r_skid_err;

  logic w_flush;
  logic w_accept;
  logic w_release;

  assign w_flush   = flush & ~flush_exempt;
  assign w_accept  = in_valid & ~r_skid_vld;
  assign w_release = r_main_vld & out_ready;

  assign in_ready  = ~r_skid_vld;
  assign out_valid = r_main_vld;
  assign out_data  = r_main_data;
  assign out_pc    = r_main_pc;
  assign out_err   = r_main_err;

  // Main/skid storage. Invalid slots are always parked at NOP_VAL/0/0 so the
  // outputs need no muxing on out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld  <= 1'b0;
      r_main_data <= NOP_D;
      r_main_pc   <= '0;
      r_main_err  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= NOP_D;
      r_skid_pc   <= '0;
      r_skid_err  <= 1'b0;
    end else if (w_flush) begin
      r_main_vld  <= 1'b0;
      r_main_data <= NOP_D;
      r_main_pc   <= '0;
      r_main_err  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= NOP_D;
      r_skid_pc   <= '0;
      r_skid_err  <= 1'b0;
    end else if (w_release && r_skid_vld) begin
      // Skid drains into main; no accept can coincide since in_ready is low.
      r_main_vld  <= 1'b1;
      r_main_data <= r_skid_data;
      r_main_pc   <= r_skid_pc;
      r_main_err  <= r_skid_err;
      r_skid_vld  <= 1'b0;
      r_skid_data <= NOP_D;
      r_skid_pc   <= '0;
      r_skid_err  <= 1'b0;
    end else if (w_accept && (!r_main_vld || w_release)) begin
      r_main_vld  <= 1'b1;
      r_main_data <= in_data;
      r_main_pc   <= in_pc;
      r_main_err  <= in_err;
    end else if (w_accept) begin
      // Main is occupied and stalled: park the new entry in the skid slot.
      r_skid_vld  <= 1'b1;
      r_skid_data <= in_data;
      r_skid_pc   <= in_pc;
      r_skid_err  <= in_err;
    end else if (w_release) begin
      r_main_vld  <= 1'b0;
      r_main_data <= NOP_D;
      r_main_pc   <= '0;
      r_main_err  <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_main_vld && !out_ready && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_pc;
  logic        in_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_pc;
  logic        out_err;
  logic        flush;
  logic        flush_exempt;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_pc        (in_pc),
    .in_err       (in_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_pc       (out_pc),
    .out_err      (out_err),
    .flush        (flush),
    .flush_exempt (flush_exempt)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] pc, input logic e);
    in_valid = v;
    in_data  = d;
    in_pc    = pc;
    in_err   = e;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_vld"},  out_valid, 1'b0);
    check({tag, "_data"}, out_data,  16'h0800);
    check({tag, "_pc"},   out_pc,    16'h0000);
    check({tag, "_err"},  out_err,   1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    out_ready    = 1'b0;
    flush        = 1'b0;
    flush_exempt = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset acts before any clock edge.
    #2;
    check_empty("rst_async");
    check("rst_rdy", in_ready, 1'b1);
    #10;
    rst = 1'b0;
    step();

    // Single entry latency.
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h0002, 1'b0);
    step();
    check("lat_vld",  out_valid, 1'b1);
    check("lat_data", out_data,  16'h1234);
    check("lat_pc",   out_pc,    16'h0002);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    check_empty("lat_drain");

    // A,B,C with downstream stalled.
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, 16'h0010, 1'b0);
    step();
    check("A_main", out_data, 16'h000A);
    check("A_rdy",  in_ready, 1'b1);
    drive(1'b1, 16'h000B, 16'h0011, 1'b0);
    step();
    check("B_skid_out", out_data, 16'h000A);
    check("B_skid_rdy", in_ready, 1'b0);
    drive(1'b1, 16'h000C, 16'h0012, 1'b0);
    step();
    check("C_held_out", out_data, 16'h000A);
    check("C_held_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("emit_A_vld", out_valid, 1'b1);
    check("emit_A",     out_data,  16'h000A);
    step();
    check("emit_B",     out_data,  16'h000B);
    check("emit_B_pc",  out_pc,    16'h0011);
    check("emit_B_rdy", in_ready,  1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("emit_C",     out_data,  16'h000C);
    check("emit_C_vld", out_valid, 1'b1);
    step();
    check_empty("abc_drain");

    // Full stage, effective flush with a competing accept.
    out_ready = 1'b0;
    drive(1'b1, 16'h00D0, 16'h0020, 1'b0);
    step();
    drive(1'b1, 16'h00E0, 16'h0021, 1'b1);
    step();
    check("full_rdy", in_ready, 1'b0);
    drive(1'b1, 16'h00F0, 16'h0022, 1'b0);
    flush = 1'b1;
    step();
    check_empty("flush");
    check("flush_rdy", in_ready, 1'b1);
    // Flush discards an accept into an empty stage as well.
    drive(1'b1, 16'h0077, 16'h0023, 1'b0);
    step();
    check_empty("flush_acc");
    flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    check_empty("flush_after");

    // Exempted flush keeps the entry.
    drive(1'b1, 16'h00AB, 16'h0030, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    flush        = 1'b1;
    flush_exempt = 1'b1;
    step();
    check("exempt_vld",  out_valid, 1'b1);
    check("exempt_data", out_data,  16'h00AB);
    flush        = 1'b0;
    flush_exempt = 1'b0;
    out_ready    = 1'b1;
    step();
    check_empty("exempt_drain");

    // Error flag travels through the skid slot.
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 16'h0040, 1'b0);
    step();
    drive(1'b1, 16'h0202, 16'h0041, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("err_first",     out_err,  1'b0);
    check("err_first_dat", out_data, 16'h0101);
    out_ready = 1'b1;
    step();
    check("err_out",     out_err,  1'b1);
    check("err_out_dat", out_data, 16'h0202);
    check("err_out_pc",  out_pc,   16'h0041);
    step();
    check_empty("err_drain");

    // Reset mid-transfer abandons held entries.
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 16'h0050, 1'b1);
    step();
    drive(1'b1, 16'h0B0B, 16'h0051, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_empty("rst_mid");
    check("rst_mid_rdy", in_ready, 1'b1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h0C0C, 16'h0052, 1'b0);
    step();
    check("post_rst_vld",  out_valid, 1'b1);
    check("post_rst_data", out_data,  16'h0C0C);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    check_empty("post_rst_drain");

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b1;
    #1;
    check("perf_rst_stall", stall_cnt, 16'd0);
    check("perf_rst_flush", flush_cnt, 16'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 16'h0060, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("perf_stall5", stall_cnt, 16'd5);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    check("perf_stall", stall_cnt, 16'd5);
    check("perf_flush", flush_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 16, width of instruction/payload field.
REQ-002 Parameter PC_W, default 16, width of incremented-PC field.
REQ-003 Parameter NOP_VAL, default 16'b0000_1000_0000_0000, payload presented whenever the stage holds no valid entry (zero-extended or truncated to DATA_W).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream instruction.
REQ-009 in_pc  input  PC_W  upstream incremented PC.
REQ-010 in_err  input  1  upstream misalignment/fetch error flag.
REQ-011 out_valid  output  1  downstream entry present.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle.
REQ-013 out_data  output  DATA_W  held instruction, or NOP_VAL when out_valid=0.
REQ-014 out_pc  output  PC_W  held PC, or 0 when out_valid=0.
REQ-015 out_err  output  1  held error flag, or 0 when out_valid=0.
REQ-016 flush  input  1  discard all held and incoming entries.
REQ-017 flush_exempt  input  1  when high, flush is ignored for this cycle (RTI in flight).

Function
REQ-018 Storage: main register (drives outputs) plus one skid register, each with its own valid bit.
REQ-019 Accept = in_valid & in_ready; release = out_valid & out_ready.
REQ-020 in_ready = ~skid_valid, driven from a register only (no combinational path from out_ready).
REQ-021 Latency: an entry accepted into an empty stage appears on outputs the next cycle.
REQ-022 Accept with main empty, or main releasing that same cycle -> entry loads main.
REQ-023 Accept with main full and not releasing -> entry loads skid; in_ready falls next cycle.
REQ-024 Release with skid valid -> skid moves to main, skid cleared, in_ready rises next cycle.
REQ-025 Release with skid valid and simultaneous accept is impossible (in_ready=0); no third entry ever exists.
REQ-026 Entries leave in acceptance order; none dropped or duplicated absent flush.
REQ-027 Effective flush = flush & ~flush_exempt; it clears both valid bits next edge and discards any same-cycle accept.
REQ-028 Flush has priority over accept, release and skid transfer.
REQ-029 Invalid registers hold NOP_VAL/0/0 payload, so out_data = NOP_VAL whenever out_valid=0.
REQ-030 out_err travels with its entry through skid and main exactly like out_data and out_pc.

Reset
REQ-031 rst asserted -> main and skid valid = 0, payloads NOP_VAL/0/0, in_ready = 1, independent of clk.
REQ-032 rst mid-transfer abandons all held entries; first post-reset accept behaves per REQ-021.

Configuration
REQ-033 Macro PIPE_STAGE_PERF_EN defined -> adds outputs stall_cnt (16 bits, increments each cycle out_valid & ~out_ready, saturates at 16'hFFFF) and flush_cnt (16 bits, increments per effective flush, saturating); both reset to 0.
REQ-034 Macro undefined -> these ports and counters are absent; all other behaviour identical.

Verification
REQ-035 Reset, then in_valid=1 in_data=16'h1234 in_pc=16'h0002 out_ready=1 -> next cycle out_valid=1 out_data=16'h1234 out_pc=16'h0002.
REQ-036 Stream A,B,C with out_ready=0 from cycle 1 -> A in main, B in skid, in_ready=0, C held upstream; raise out_ready -> A,B,C emitted in order on consecutive cycles.
REQ-037 Main and skid full, flush=1 flush_exempt=0 -> next cycle out_valid=0, out_data=16'h0800, in_ready=1.
REQ-038 Main full, flush=1 flush_exempt=1 -> entry retained, out_valid stays 1, data unchanged.
REQ-039 in_err=1 with entry while out_ready=0 -> entry passes via skid; out_err=1 exactly on the cycle it occupies the outputs.
REQ-040 PIPE_STAGE_PERF_EN defined, out_ready held low 5 cycles with valid entry, then one effective flush -> stall_cnt=5, flush_cnt=1.
